// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word and local-history-predictor FSM states.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic {
        INIT,
        RUN
    } lc3b_lhp_state;

    function automatic int unsigned max_bits(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/predictor_array.sv
// Small register-file table: one synchronous write port, two combinational read ports.
module predictor_array #(
    parameter int unsigned width      = 1,
    parameter int unsigned index_bits = 1
) (
    input  logic                  clk,
    input  logic                  write,
    input  logic [index_bits-1:0] index_in,
    input  logic [width-1:0]      datain,
    input  logic [index_bits-1:0] rindex,
    output logic [width-1:0]      rdataout,
    input  logic [index_bits-1:0] windex,
    output logic [width-1:0]      wdataout
);

    logic [width-1:0] data [2**index_bits];

    // Contents are initialised by the owner's sweep, so no reset here.
    always_ff @(posedge clk) begin
        if (write) begin
            data[index_in] <= datain;
        end
    end

    assign rdataout = data[rindex];
    assign wdataout = data[windex];

endmodule

// File: rtl/local_history_predictor.sv
// Two-level local branch predictor: per-PC history (LHT) selects a saturating counter (PHT).
module local_history_predictor
    import lc3b_types::*;
#(
    parameter int unsigned PC_LSB         = 1,
    parameter int unsigned LHT_INDEX_BITS = 6,
    parameter int unsigned HIST_LEN       = 4,
    parameter int unsigned PHT_PC_BITS    = 2,
    parameter int unsigned CTR_WIDTH      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] read_pc,
    output logic        prediction,
    output logic        ready,
    input  logic [15:0] write_pc,
    input  logic        taken,
    input  logic        write
);

    localparam int unsigned PHT_INDEX_BITS = PHT_PC_BITS + HIST_LEN;
    localparam int unsigned SWEEP_BITS     = max_bits(LHT_INDEX_BITS, PHT_INDEX_BITS);
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

    lc3b_lhp_state state, state_next;
    logic [SWEEP_BITS-1:0] cnt, cnt_next;

    logic [LHT_INDEX_BITS-1:0] lht_ridx, lht_widx, lht_idx_in;
    logic [HIST_LEN-1:0]       lht_rdata, lht_wdata, lht_din, hist_next;
    logic                      lht_we;

    logic [PHT_INDEX_BITS-1:0] pht_ridx, pht_widx, pht_idx_in;
    logic [CTR_WIDTH-1:0]      pht_rdata, pht_wdata, pht_din, ctr_next;
    logic                      pht_we;

    logic lht_in_range, pht_in_range;
    logic unused_pc_bits;

    assign unused_pc_bits = ^{read_pc, write_pc};

    assign lht_ridx = read_pc[PC_LSB +: LHT_INDEX_BITS];
    assign lht_widx = write_pc[PC_LSB +: LHT_INDEX_BITS];

    generate
        if (PHT_PC_BITS == 0) begin : g_pht_hist_only
            assign pht_ridx = lht_rdata;
            assign pht_widx = lht_wdata;
        end else begin : g_pht_pc_hist
            assign pht_ridx = {read_pc[PC_LSB +: PHT_PC_BITS], lht_rdata};
            assign pht_widx = {write_pc[PC_LSB +: PHT_PC_BITS], lht_wdata};
        end

        if (HIST_LEN == 1) begin : g_hist_one
            assign hist_next = taken;
        end else begin : g_hist_shift
            assign hist_next = {lht_wdata[HIST_LEN-2:0], taken};
        end
    endgenerate

    always_comb begin
        ctr_next = pht_wdata;
        if (taken && (pht_wdata != '1)) begin
            ctr_next = pht_wdata + CTR_WIDTH'(1);
        end else if (!taken && (pht_wdata != '0)) begin
            ctr_next = pht_wdata - CTR_WIDTH'(1);
        end
    end

    // The sweep covers the larger table; the smaller one only takes the low part of it.
    assign lht_in_range = ((cnt >> LHT_INDEX_BITS) == '0);
    assign pht_in_range = ((cnt >> PHT_INDEX_BITS) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        lht_we     = 1'b0;
        lht_idx_in = lht_widx;
        lht_din    = hist_next;
        pht_we     = 1'b0;
        pht_idx_in = pht_widx;
        pht_din    = ctr_next;
        if (!reset) begin
            unique case (state)
                INIT: begin
                    lht_we     = lht_in_range;
                    lht_idx_in = cnt[LHT_INDEX_BITS-1:0];
                    lht_din    = '0;
                    pht_we     = pht_in_range;
                    pht_idx_in = cnt[PHT_INDEX_BITS-1:0];
                    pht_din    = CTR_INIT;
                    cnt_next   = cnt + SWEEP_BITS'(1);
                    if (cnt == '1) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    lht_we = write;
                    pht_we = write;
                end
                default: begin
                    state_next = INIT;
                end
            endcase
        end
    end

    predictor_array #(
        .width      (HIST_LEN),
        .index_bits (LHT_INDEX_BITS)
    ) lht (
        .clk      (clk),
        .write    (lht_we),
        .index_in (lht_idx_in),
        .datain   (lht_din),
        .rindex   (lht_ridx),
        .rdataout (lht_rdata),
        .windex   (lht_widx),
        .wdataout (lht_wdata)
    );

    predictor_array #(
        .width      (CTR_WIDTH),
        .index_bits (PHT_INDEX_BITS)
    ) pht (
        .clk      (clk),
        .write    (pht_we),
        .index_in (pht_idx_in),
        .datain   (pht_din),
        .rindex   (pht_ridx),
        .rdataout (pht_rdata),
        .windex   (pht_widx),
        .wdataout (pht_wdata)
    );

    assign ready      = (state == RUN);
    assign prediction = ready & pht_rdata[CTR_WIDTH-1];

endmodule

// File: tb/tb_local_history_predictor.sv
// Scoreboard bench: default build plus a CTR_WIDTH=3 / HIST_LEN=1 build side by side.
module tb_local_history_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] read_pc, write_pc, read_pc_b, write_pc_b;
    logic        taken, write, taken_b, write_b;
    logic        prediction, ready, prediction_b, ready_b;

    int unsigned checks = 0;
    int unsigned failures = 0;

    bit exp_q[$];

    logic [3:0] a_lht [64];
    logic [1:0] a_pht [64];
    logic       b_lht [64];
    logic [2:0] b_pht [8];

    always #5 clk = ~clk;

    local_history_predictor dut (
        .clk        (clk),
        .reset      (reset),
        .read_pc    (read_pc),
        .prediction (prediction),
        .ready      (ready),
        .write_pc   (write_pc),
        .taken      (taken),
        .write      (write)
    );

    local_history_predictor #(
        .PC_LSB         (1),
        .LHT_INDEX_BITS (6),
        .HIST_LEN       (1),
        .PHT_PC_BITS    (2),
        .CTR_WIDTH      (3)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .read_pc    (read_pc_b),
        .prediction (prediction_b),
        .ready      (ready_b),
        .write_pc   (write_pc_b),
        .taken      (taken_b),
        .write      (write_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_init();
        for (int i = 0; i < 64; i++) begin
            a_lht[i] = '0;
            a_pht[i] = 2'd1;
            b_lht[i] = 1'b0;
        end
        for (int i = 0; i < 8; i++) b_pht[i] = 3'd3;
    endtask

    function automatic bit a_pred(input logic [15:0] pc);
        logic [5:0] pi;
        pi = {pc[2:1], a_lht[pc[6:1]]};
        return a_pht[pi][1];
    endfunction

    task automatic a_upd(input logic [15:0] pc, input logic t);
        logic [3:0] h;
        logic [5:0] pi;
        logic [1:0] c;
        h  = a_lht[pc[6:1]];
        pi = {pc[2:1], h};
        c  = a_pht[pi];
        if (t && c != 2'd3) c = c + 2'd1;
        else if (!t && c != 2'd0) c = c - 2'd1;
        a_pht[pi] = c;
        a_lht[pc[6:1]] = {h[2:0], t};
    endtask

    function automatic bit b_pred(input logic [15:0] pc);
        logic [2:0] pi;
        pi = {pc[2:1], b_lht[pc[6:1]]};
        return b_pht[pi][2];
    endfunction

    task automatic b_upd(input logic [15:0] pc, input logic t);
        logic       h;
        logic [2:0] pi;
        logic [2:0] c;
        h  = b_lht[pc[6:1]];
        pi = {pc[2:1], h};
        c  = b_pht[pi];
        if (t && c != 3'd7) c = c + 3'd1;
        else if (!t && c != 3'd0) c = c - 3'd1;
        b_pht[pi] = c;
        b_lht[pc[6:1]] = t;
    endtask

    task automatic test_reset();
        bit e;
        reset = 1'b1;
        write = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (ready !== 1'b0 || ready_b !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready cycle=%0d got=%b/%b exp=0", i, ready, ready_b);
            end
            read_pc = 16'($urandom);
            exp_q.push_back(1'b0);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (prediction !== e) begin
                failures++;
                $display("FAIL reset_pred cycle=%0d got=%b exp=%b", i, prediction, e);
            end
            step();
        end
        checks++;
        if (ready !== 1'b1 || ready_b !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_rise got=%b/%b exp=1", ready, ready_b);
        end
        model_init();
    endtask

    task automatic test_init_ignores_writes();
        bit e;
        reset = 1'b1;
        write = 1'b1;
        write_b = 1'b1;
        write_pc = 16'($urandom_range(0, 63) << 1);
        write_pc_b = write_pc;
        taken = 1'b1;
        taken_b = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            write_pc = 16'($urandom_range(0, 63) << 1);
            write_pc_b = write_pc;
            taken = 1'($urandom);
            taken_b = taken;
            step();
        end
        write = 1'b0;
        write_b = 1'b0;
        model_init();
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL init_ready got=%b exp=1", ready);
        end
        for (int p = 0; p <= 16'h007E; p += 2) begin
            read_pc = 16'(p);
            read_pc_b = 16'(p);
            exp_q.push_back(a_pred(read_pc));
            exp_q.push_back(b_pred(read_pc_b));
            #1;
            e = exp_q.pop_front();
            checks++;
            if (prediction !== e) begin
                failures++;
                $display("FAIL init_clean pc=%h got=%b exp=%b", read_pc, prediction, e);
            end
            e = exp_q.pop_front();
            checks++;
            if (prediction_b !== e) begin
                failures++;
                $display("FAIL init_clean_b pc=%h got=%b exp=%b", read_pc_b, prediction_b, e);
            end
        end
    endtask

    task automatic test_saturation();
        bit e;
        read_pc = 16'h0040;
        write_pc = 16'h0040;
        write = 1'b1;
        for (int i = 0; i < 18; i++) begin
            taken = (i < 16);
            step();
            a_upd(write_pc, taken);
            exp_q.push_back(a_pred(read_pc));
            e = exp_q.pop_front();
            checks++;
            if (prediction !== e) begin
                failures++;
                $display("FAIL saturation step=%0d got=%b exp=%b", i, prediction, e);
            end
        end
        write = 1'b0;
    endtask

    task automatic test_same_cycle();
        bit e;
        for (int i = 0; i < 6; i++) begin
            read_pc = 16'h0010;
            write_pc = 16'h0010;
            taken = 1'b1;
            write = 1'b1;
            exp_q.push_back(a_pred(read_pc));
            #1;
            e = exp_q.pop_front();
            checks++;
            if (prediction !== e) begin
                failures++;
                $display("FAIL same_cycle_old step=%0d got=%b exp=%b", i, prediction, e);
            end
            step();
            a_upd(write_pc, taken);
            write = 1'b0;
            exp_q.push_back(a_pred(read_pc));
            #1;
            e = exp_q.pop_front();
            checks++;
            if (prediction !== e) begin
                failures++;
                $display("FAIL same_cycle_new step=%0d got=%b exp=%b", i, prediction, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit e;
        logic [7:0] pattern;
        pattern = 8'b0001_1111;
        read_pc = 16'h0022;
        write_pc = 16'h0022;
        write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            taken = pattern[i];
            step();
            a_upd(write_pc, taken);
            exp_q.push_back(a_pred(read_pc));
            e = exp_q.pop_front();
            checks++;
            if (prediction !== e) begin
                failures++;
                $display("FAIL back_to_back step=%0d got=%b exp=%b", i, prediction, e);
            end
        end
        write = 1'b0;
        #1;
    endtask

    task automatic test_pattern();
        bit e;
        read_pc = 16'h0100;
        write_pc = 16'h0100;
        write = 1'b1;
        for (int i = 0; i < 40; i++) begin
            taken = (i % 2 == 0);
            step();
            a_upd(write_pc, taken);
        end
        for (int i = 40; i < 60; i++) begin
            taken = (i % 2 == 0);
            exp_q.push_back(taken);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (prediction !== e) begin
                failures++;
                $display("FAIL pattern step=%0d got=%b exp=%b", i, prediction, e);
            end
            step();
            a_upd(write_pc, taken);
        end
        write = 1'b0;
    endtask

    task automatic test_random();
        bit e;
        for (int i = 0; i < 300; i++) begin
            read_pc = 16'($urandom_range(0, 15) << 1);
            write_pc = 16'($urandom_range(0, 15) << 1);
            taken = 1'($urandom);
            write = 1'($urandom);
            exp_q.push_back(a_pred(read_pc));
            #1;
            e = exp_q.pop_front();
            checks++;
            if (prediction !== e) begin
                failures++;
                $display("FAIL random step=%0d pc=%h got=%b exp=%b", i, read_pc, prediction, e);
            end
            step();
            if (write) a_upd(write_pc, taken);
        end
        write = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 30; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (ready !== 1'b0 || ready_b !== 1'b0) begin
                failures++;
                $display("FAIL midsweep_ready cycle=%0d got=%b/%b exp=0", i, ready, ready_b);
            end
            step();
        end
        checks++;
        if (ready !== 1'b1 || ready_b !== 1'b1) begin
            failures++;
            $display("FAIL midsweep_rise got=%b/%b exp=1", ready, ready_b);
        end
        model_init();
    endtask

    task automatic test_saturation_b();
        bit e;
        read_pc_b = 16'h0040;
        write_pc_b = 16'h0040;
        exp_q.push_back(b_pred(read_pc_b));
        #1;
        e = exp_q.pop_front();
        checks++;
        if (prediction_b !== e) begin
            failures++;
            $display("FAIL sat_b_initial got=%b exp=%b", prediction_b, e);
        end
        write_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            taken_b = (i < 12);
            step();
            b_upd(write_pc_b, taken_b);
            exp_q.push_back(b_pred(read_pc_b));
            e = exp_q.pop_front();
            checks++;
            if (prediction_b !== e) begin
                failures++;
                $display("FAIL sat_b step=%0d got=%b exp=%b", i, prediction_b, e);
            end
        end
        write_b = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        read_pc = '0;
        write_pc = '0;
        taken = 1'b0;
        write = 1'b0;
        read_pc_b = '0;
        write_pc_b = '0;
        taken_b = 1'b0;
        write_b = 1'b0;
        step();
        test_reset();
        test_init_ignores_writes();
        test_saturation();
        test_same_cycle();
        test_back_to_back();
        test_pattern();
        test_random();
        test_reset_mid_sweep();
        test_saturation_b();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
